// File: rtl/cc_psr_branch.sv
// Processor status register fed by the ALU: active-low flag capture, direct PSR write,
// registered branch-condition evaluation, plus a sticky V bit and saturating V-event counter.
module cc_psr_branch #(
    parameter int DATAWIDTH_BUS   = 32,
    parameter int DATAWIDTH_COND  = 4,
    parameter int DATAWIDTH_OVCNT = 8
) (
    input  logic                       CC_PSR_CLOCK_50,
    input  logic                       CC_PSR_RESET_InLow,
    input  logic                       CC_PSR_negative_InLow,
    input  logic                       CC_PSR_zero_InLow,
    input  logic                       CC_PSR_overflow_InLow,
    input  logic                       CC_PSR_carry_InLow,
    input  logic                       CC_PSR_SetCode_In,
    input  logic                       CC_PSR_write_In,
    input  logic [DATAWIDTH_BUS-1:0]   CC_PSR_data_InBus,
    input  logic                       CC_PSR_branchReq_In,
    input  logic [DATAWIDTH_COND-1:0]  CC_PSR_cond_InBus,
    output logic [DATAWIDTH_BUS-1:0]   CC_PSR_data_OutBus,
    output logic [3:0]                 CC_PSR_flags_OutBus,
    output logic                       CC_PSR_branchTaken_Out,
    output logic                       CC_PSR_branchValid_Out,
    output logic [DATAWIDTH_OVCNT-1:0] CC_PSR_ovCount_OutBus
);

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    flags_t                     flags_q, flags_d;
    logic                       sv_q, sv_d;
    logic [DATAWIDTH_OVCNT-1:0] ovcnt_q, ovcnt_d;
    logic                       taken_q, taken_d;
    logic                       valid_q, valid_d;
    logic                       v_load;
    logic                       unused_bits;

    // cond[3] inverts the base test selected by cond[2:0]; base 0 is "never".
    function automatic logic cond_eval(input logic [3:0] cond, input flags_t f);
        logic base;
        case (cond[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = f.z;
            3'd2:    base = f.z | (f.n ^ f.v);
            3'd3:    base = f.n ^ f.v;
            3'd4:    base = f.c | f.z;
            3'd5:    base = f.c;
            3'd6:    base = f.n;
            default: base = f.v;
        endcase
        return base ^ cond[3];
    endfunction

    assign v_load      = !CC_PSR_write_In && CC_PSR_SetCode_In && !CC_PSR_overflow_InLow;
    assign unused_bits = ^CC_PSR_data_InBus[DATAWIDTH_BUS-1:5];

    always_comb begin
        flags_d = flags_q;
        sv_d    = sv_q;
        ovcnt_d = ovcnt_q;
        if (CC_PSR_write_In) begin
            {sv_d, flags_d} = CC_PSR_data_InBus[4:0];
        end else if (CC_PSR_SetCode_In) begin
            flags_d = ~{CC_PSR_negative_InLow, CC_PSR_zero_InLow,
                        CC_PSR_overflow_InLow, CC_PSR_carry_InLow};
            sv_d    = sv_q | ~CC_PSR_overflow_InLow;
        end
        if (v_load && (ovcnt_q != '1))
            ovcnt_d = ovcnt_q + {{(DATAWIDTH_OVCNT-1){1'b0}}, 1'b1};
        // Evaluate against flags_d so a request sees the flags being loaded this edge.
        valid_d = CC_PSR_branchReq_In;
        taken_d = CC_PSR_branchReq_In ? cond_eval(CC_PSR_cond_InBus[3:0], flags_d) : taken_q;
    end

    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            flags_q <= '0;
            sv_q    <= 1'b0;
            ovcnt_q <= '0;
            taken_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sv_q    <= sv_d;
            ovcnt_q <= ovcnt_d;
            taken_q <= taken_d;
            valid_q <= valid_d;
        end
    end

    assign CC_PSR_data_OutBus     = {{(DATAWIDTH_BUS-5){1'b0}}, sv_q, flags_q};
    assign CC_PSR_flags_OutBus    = flags_q;
    assign CC_PSR_branchTaken_Out = taken_q;
    assign CC_PSR_branchValid_Out = valid_q;
    assign CC_PSR_ovCount_OutBus  = ovcnt_q;

endmodule

// File: tb/tb_cc_psr_branch.sv
// Directed bench for cc_psr_branch: flag load, write priority, forwarding, condition map,
// counter saturation with a 2-bit counter, and asynchronous mid-operation reset.
module tb_cc_psr_branch;

    logic        clk;
    logic        rst_n;
    logic        neg_l, zero_l, ovf_l, car_l;
    logic        setcode, wr;
    logic [31:0] din;
    logic        req;
    logic [3:0]  cond;
    logic [31:0] dout;
    logic [3:0]  flags;
    logic        taken, valid;
    logic [1:0]  ovcnt;

    int checks = 0;
    int errors = 0;

    cc_psr_branch #(
        .DATAWIDTH_BUS  (32),
        .DATAWIDTH_COND (4),
        .DATAWIDTH_OVCNT(2)
    ) dut (
        .CC_PSR_CLOCK_50       (clk),
        .CC_PSR_RESET_InLow    (rst_n),
        .CC_PSR_negative_InLow (neg_l),
        .CC_PSR_zero_InLow     (zero_l),
        .CC_PSR_overflow_InLow (ovf_l),
        .CC_PSR_carry_InLow    (car_l),
        .CC_PSR_SetCode_In     (setcode),
        .CC_PSR_write_In       (wr),
        .CC_PSR_data_InBus     (din),
        .CC_PSR_branchReq_In   (req),
        .CC_PSR_cond_InBus     (cond),
        .CC_PSR_data_OutBus    (dout),
        .CC_PSR_flags_OutBus   (flags),
        .CC_PSR_branchTaken_Out(taken),
        .CC_PSR_branchValid_Out(valid),
        .CC_PSR_ovCount_OutBus (ovcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  dout, 32'h0);
        check({tag, "_flags"}, {28'h0, flags}, 32'h0);
        check({tag, "_valid"}, {31'h0, valid}, 32'h0);
        check({tag, "_taken"}, {31'h0, taken}, 32'h0);
        check({tag, "_ovcnt"}, {30'h0, ovcnt}, 32'h0);
    endtask

    initial begin
        logic [15:0] cond_tbl;
        int          exp_ov[5];
        exp_ov   = '{1, 2, 3, 3, 3};
        // flags n=1,z=0,v=0,c=0: expected taken for cond 0..15 (bit i)
        cond_tbl = 16'b1011_0011_0100_1100;

        rst_n = 1'b0; neg_l = 1'b1; zero_l = 1'b1; ovf_l = 1'b1; car_l = 1'b1;
        setcode = 1'b0; wr = 1'b0; din = 32'h0; req = 1'b0; cond = 4'h0;

        // power-on reset
        tick();
        check_all_zero("por");
        rst_n = 1'b1;
        tick();
        check("por_valid_after", {31'h0, valid}, 32'h0);

        // T2 flag load
        setcode = 1'b1; {neg_l, zero_l, ovf_l, car_l} = 4'b1010;
        tick();
        setcode = 1'b0; {neg_l, zero_l, ovf_l, car_l} = 4'b1111;
        check("t2_flags", {28'h0, flags}, 32'h5);
        check("t2_data",  dout, 32'h0000_0005);
        check("t2_ovcnt", {30'h0, ovcnt}, 32'h0);

        // T3 write beats SetCode
        wr = 1'b1; din = 32'h0000_001F; setcode = 1'b1;
        tick();
        wr = 1'b0; setcode = 1'b0;
        check("t3_flags", {28'h0, flags}, 32'hF);
        check("t3_data",  dout, 32'h0000_001F);

        // upper write bits are ignored
        wr = 1'b1; din = 32'hFFFF_FFE0;
        tick();
        wr = 1'b0;
        check("wr_upper_ignored", dout, 32'h0);

        // T4 forwarding of SetCode flags into same-edge branch
        req = 1'b1; cond = 4'b0001; setcode = 1'b1; zero_l = 1'b0;
        tick();
        req = 1'b0; setcode = 1'b0; zero_l = 1'b1;
        check("t4_valid", {31'h0, valid}, 32'h1);
        check("t4_taken", {31'h0, taken}, 32'h1);
        check("t4_flags", {28'h0, flags}, 32'h4);
        tick();
        check("t4_valid_drop", {31'h0, valid}, 32'h0);
        check("t4_taken_hold", {31'h0, taken}, 32'h1);

        // forwarding of a write: write clears z, be must be not-taken
        wr = 1'b1; din = 32'h0; req = 1'b1; cond = 4'b0001;
        tick();
        wr = 1'b0; req = 1'b0;
        check("fwd_wr_valid", {31'h0, valid}, 32'h1);
        check("fwd_wr_taken", {31'h0, taken}, 32'h0);

        // T5 signed compare with n=1, v=0, back-to-back requests
        setcode = 1'b1; neg_l = 1'b0;
        tick();
        setcode = 1'b0; neg_l = 1'b1;
        check("t5_flags", {28'h0, flags}, 32'h8);
        req = 1'b1; cond = 4'b0011;
        tick();
        check("t5_bl_valid", {31'h0, valid}, 32'h1);
        check("t5_bl_taken", {31'h0, taken}, 32'h1);
        cond = 4'b1011;
        tick();
        check("t5_bge_valid", {31'h0, valid}, 32'h1);
        check("t5_bge_taken", {31'h0, taken}, 32'h0);
        cond = 4'b0000;
        tick();
        check("t5_never_valid", {31'h0, valid}, 32'h1);
        check("t5_never_taken", {31'h0, taken}, 32'h0);
        cond = 4'b1000;
        tick();
        check("t5_always_valid", {31'h0, valid}, 32'h1);
        check("t5_always_taken", {31'h0, taken}, 32'h1);
        req = 1'b0;
        tick();
        check("t5_valid_end", {31'h0, valid}, 32'h0);

        // full condition map against n=1,z=0,v=0,c=0
        for (int i = 0; i < 16; i++) begin
            req = 1'b1; cond = 4'(i);
            tick();
            check($sformatf("cmap_%0d", i), {31'h0, taken}, {31'h0, cond_tbl[i]});
        end
        req = 1'b0;
        tick();

        // write suppresses the overflow count
        wr = 1'b1; din = 32'h0; setcode = 1'b1; ovf_l = 1'b0;
        tick();
        wr = 1'b0; setcode = 1'b0; ovf_l = 1'b1;
        check("wr_no_count", {30'h0, ovcnt}, 32'h0);
        check("wr_no_sticky", dout, 32'h0);

        // T6 counter saturation
        for (int i = 0; i < 5; i++) begin
            setcode = 1'b1; ovf_l = 1'b0;
            tick();
            check($sformatf("t6_ovcnt_%0d", i), {30'h0, ovcnt}, 32'(exp_ov[i]));
        end
        setcode = 1'b0; ovf_l = 1'b1;
        check("t6_sticky", dout, 32'h0000_0012);
        // a V-clear load keeps sticky set
        setcode = 1'b1;
        tick();
        setcode = 1'b0;
        check("t6_sticky_hold", dout, 32'h0000_0010);
        wr = 1'b1; din = 32'h0;
        tick();
        wr = 1'b0;
        check("t6_wr_clear_sv", dout, 32'h0);
        check("t6_ovcnt_kept", {30'h0, ovcnt}, 32'h3);

        // T1 mid-operation reset with a request in flight
        req = 1'b1; cond = 4'b1000;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_valid_after", {31'h0, valid}, 32'h0);
        check("midrst_taken_after", {31'h0, taken}, 32'h0);
        check("midrst_ovcnt_after", {30'h0, ovcnt}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
